// File: rtl/lstm_layer_seq.sv
// lstm_layer_seq: control sequencer for one LSTM layer.
// For every timestep t and every cell it runs CLEAR -> ACC (K cycles) ->
// DRAIN (PIPE_LAT cycles) -> WRITE. After the final write it runs DONE.
// All outputs are registered. Each output value is computed from the next
// state and next counters, so a registered output always matches the state
// it is registered with.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a sequence (sampled only in IDLE)
//   hold                  stall input, present only with LSTM_SEQ_HOLD_EN
//   busy, done            sequence active / one-cycle completion pulse
//   acc_rst, acc_x, acc_h accumulator clear / accumulate x*W / accumulate h*U
//   addr_x, rd_addr_w/u/b/h   operand read addresses
//   wr_h, wr_c, wr_addr_h/c   state memory write enables and addresses
//   cur_t, cur_cell       current timestep and cell
//
// Optional feature macro: LSTM_SEQ_HOLD_EN. It adds the hold input, which
// freezes the sequence and masks all strobes while it is high.
//
// Handshake: start is a level sampled only in IDLE. There is no ready
// signal, and a start seen outside IDLE is dropped. done marks completion.
module lstm_layer_seq #(
  parameter int N_INPUT    = 53,
  parameter int N_CELL     = 53,
  parameter int TIMESTEP   = 7,
  parameter int PIPE_LAT   = 1,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
`ifdef LSTM_SEQ_HOLD_EN
  input  logic                  hold,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  acc_rst,
  output logic                  acc_x,
  output logic                  acc_h,
  output logic [ADDR_WIDTH-1:0] addr_x,
  output logic [ADDR_WIDTH-1:0] rd_addr_w,
  output logic [ADDR_WIDTH-1:0] rd_addr_u,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [ADDR_WIDTH-1:0] rd_addr_h,
  output logic                  wr_h,
  output logic                  wr_c,
  output logic [ADDR_WIDTH-1:0] wr_addr_h,
  output logic [ADDR_WIDTH-1:0] wr_addr_c,
  output logic [ADDR_WIDTH-1:0] cur_t,
  output logic [ADDR_WIDTH-1:0] cur_cell
);
  localparam int AW = ADDR_WIDTH;
  localparam int K  = (N_INPUT > N_CELL) ? N_INPUT : N_CELL;
  localparam logic [AW-1:0] NI   = AW'(N_INPUT);
  localparam logic [AW-1:0] NC   = AW'(N_CELL);
  localparam logic [AW-1:0] KM1  = AW'(K - 1);
  localparam logic [AW-1:0] NCM1 = AW'(N_CELL - 1);
  localparam logic [AW-1:0] TM1  = AW'(TIMESTEP - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);
  // When PIPE_LAT is 0 this value is all ones. DRAIN is never entered in
  // that case, so the value is never used.
  localparam logic [31:0] DCNT_LAST = 32'(PIPE_LAT - 1);
  localparam longint ADDR_SPAN = longint'(1) << AW;

  // Every address product must fit in the address space.
  if (longint'(TIMESTEP) * N_INPUT > ADDR_SPAN ||
      longint'(TIMESTEP) * N_CELL  > ADDR_SPAN ||
      longint'(N_CELL)   * K       > ADDR_SPAN) begin : g_addr_range_check
    $error("lstm_layer_seq: address products exceed 2**ADDR_WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACC, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] t_q, t_d, cell_q, cell_d, k_q, k_d;
  logic [31:0]   dcnt_q, dcnt_d;
  logic          hold_act;

`ifdef LSTM_SEQ_HOLD_EN
  // Hold has no effect in IDLE, so it never blocks a start.
  assign hold_act = hold && (state_q != S_IDLE);
`else
  assign hold_act = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      cell_q  <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      cell_q  <= cell_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    cell_d  = cell_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    if (!hold_act) begin
      unique case (state_q)
        S_IDLE: if (start) begin
          state_d = S_CLEAR;
          t_d     = '0;
          cell_d  = '0;
        end
        S_CLEAR: begin
          state_d = S_ACC;
          k_d     = '0;
        end
        S_ACC: if (k_q == KM1) begin
          state_d = (PIPE_LAT == 0) ? S_WRITE : S_DRAIN;
          dcnt_d  = '0;
        end else begin
          k_d = k_q + ONE;
        end
        S_DRAIN: if (dcnt_q == DCNT_LAST) state_d = S_WRITE;
                 else dcnt_d = dcnt_q + 32'd1;
        S_WRITE: if (cell_q != NCM1) begin
          cell_d  = cell_q + ONE;
          state_d = S_CLEAR;
        end else if (t_q != TM1) begin
          cell_d  = '0;
          t_d     = t_q + ONE;
          state_d = S_CLEAR;
        end else begin
          state_d = S_DONE;
        end
        // DONE stays one more cycle only if hold masked its done pulse,
        // so the pulse is emitted after release.
        S_DONE: if (done) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs.
  logic          in_acc, x_ok, h_ok;
  logic [AW-1:0] t_m1;
  assign in_acc = (state_d == S_ACC) && !hold_act;
  assign x_ok   = k_d < NI;
  // h(-1) is zero at t=0, so the h operand is never read there.
  assign h_ok   = (k_d < NC) && (t_d != '0);
  assign t_m1   = t_d - ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      acc_rst   <= 1'b0;
      acc_x     <= 1'b0;
      acc_h     <= 1'b0;
      addr_x    <= '0;
      rd_addr_w <= '0;
      rd_addr_u <= '0;
      rd_addr_b <= '0;
      rd_addr_h <= '0;
      wr_h      <= 1'b0;
      wr_c      <= 1'b0;
      wr_addr_h <= '0;
      wr_addr_c <= '0;
      cur_t     <= '0;
      cur_cell  <= '0;
    end else begin
      busy    <= (state_d == S_CLEAR) || (state_d == S_ACC) ||
                 (state_d == S_DRAIN) || (state_d == S_WRITE);
      done    <= (state_d == S_DONE)  && !hold_act;
      acc_rst <= (state_d == S_CLEAR) && !hold_act;
      acc_x   <= in_acc && x_ok;
      acc_h   <= in_acc && h_ok;
      wr_h    <= (state_d == S_WRITE) && !hold_act;
      wr_c    <= (state_d == S_WRITE) && !hold_act;
      cur_t   <= t_d;
      cur_cell <= cell_d;
      // Each address keeps the last value of its own valid term.
      if (in_acc && x_ok) begin
        addr_x    <= t_d * NI + k_d;
        rd_addr_w <= cell_d * NI + k_d;
      end
      if (in_acc && (k_d < NC)) rd_addr_u <= cell_d * NC + k_d;
      if (in_acc && h_ok)       rd_addr_h <= t_m1 * NC + k_d;
      if ((state_d == S_CLEAR) && !hold_act) rd_addr_b <= cell_d;
      if ((state_d == S_WRITE) && !hold_act) begin
        wr_addr_h <= t_d * NC + cell_d;
        wr_addr_c <= t_d * NC + cell_d;
      end
    end
  end
endmodule

// File: tb/tb_lstm_layer_seq.sv
// Directed bench for lstm_layer_seq.
// u_s is a small instance (N_INPUT=3, N_CELL=2, TIMESTEP=2, PIPE_LAT=1,
// giving K=3 and 6 cycles per cell). u_d is an instance with the default
// parameters (53/53/7/1).
module tb_lstm_layer_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_s = 1'b0;
  logic start_d = 1'b0;
  always #5 clk = ~clk;

  logic busy_s, done_s, acc_rst_s, acc_x_s, acc_h_s, wr_h_s, wr_c_s;
  logic [11:0] addr_x_s, rd_w_s, rd_u_s, rd_b_s, rd_h_s, wa_h_s, wa_c_s, t_s, cell_s;
  logic busy_d, done_d, acc_rst_d, acc_x_d, acc_h_d, wr_h_d, wr_c_d;
  logic [11:0] addr_x_d, rd_w_d, rd_u_d, rd_b_d, rd_h_d, wa_h_d, wa_c_d, t_d, cell_d;

  lstm_layer_seq #(.N_INPUT(3), .N_CELL(2), .TIMESTEP(2), .PIPE_LAT(1), .ADDR_WIDTH(12)) u_s (
    .clk(clk), .rst_n(rst_n), .start(start_s),
`ifdef LSTM_SEQ_HOLD_EN
    .hold(1'b0),
`endif
    .busy(busy_s), .done(done_s), .acc_rst(acc_rst_s), .acc_x(acc_x_s), .acc_h(acc_h_s),
    .addr_x(addr_x_s), .rd_addr_w(rd_w_s), .rd_addr_u(rd_u_s), .rd_addr_b(rd_b_s),
    .rd_addr_h(rd_h_s), .wr_h(wr_h_s), .wr_c(wr_c_s), .wr_addr_h(wa_h_s),
    .wr_addr_c(wa_c_s), .cur_t(t_s), .cur_cell(cell_s));

  lstm_layer_seq u_d (
    .clk(clk), .rst_n(rst_n), .start(start_d),
`ifdef LSTM_SEQ_HOLD_EN
    .hold(1'b0),
`endif
    .busy(busy_d), .done(done_d), .acc_rst(acc_rst_d), .acc_x(acc_x_d), .acc_h(acc_h_d),
    .addr_x(addr_x_d), .rd_addr_w(rd_w_d), .rd_addr_u(rd_u_d), .rd_addr_b(rd_b_d),
    .rd_addr_h(rd_h_d), .wr_h(wr_h_d), .wr_c(wr_c_d), .wr_addr_h(wa_h_d),
    .wr_addr_c(wa_c_d), .cur_t(t_d), .cur_cell(cell_d));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int busy_n, done_n, done_c, acch_t0, wrc_bad, wr_seen;
  int wr_q[$], wrc_q[$], xs[$], ws[$], hs[$], us[$], x1[$];
  int b_bad;
  int lim, last_wr, max_x, max_w, max_u, max_h, wr_n;

  initial begin
    // Reset state.
    repeat (3) tick();
    check("rst_busy", busy_s, 0);
    check("rst_done", done_s, 0);
    check("rst_wr_h", wr_h_s, 0);
    check("rst_addr_x", addr_x_s, 0);
    check("rst_cur_t", t_s, 0);
    rst_n = 1'b1;
    tick();

    // Full run of the small instance. c = 0 is the first CLEAR cycle.
    // A start pulse at c=9..10 lands while busy and must be ignored.
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    check("first_acc_rst", acc_rst_s, 1);
    check("first_busy", busy_s, 1);
    busy_n = 0; done_n = 0; done_c = -1; acch_t0 = 0; wrc_bad = 0; b_bad = 0;
    for (int c = 0; c < 30; c++) begin
      if (busy_s) busy_n++;
      if (wr_h_s) begin wr_q.push_back(int'(wa_h_s)); wrc_q.push_back(c); end
      if (wr_h_s !== wr_c_s || wa_h_s !== wa_c_s) wrc_bad++;
      if (done_s) begin done_n++; done_c = c; end
      if (acc_h_s && t_s == 0) acch_t0++;
      if (t_s == 0 && cell_s == 1 && acc_x_s) begin
        xs.push_back(int'(addr_x_s)); ws.push_back(int'(rd_w_s));
        if (rd_b_s != 1) b_bad++;
      end
      if (t_s == 1 && cell_s == 0) begin
        if (acc_h_s) begin hs.push_back(int'(rd_h_s)); us.push_back(int'(rd_u_s)); end
        if (acc_x_s) x1.push_back(int'(addr_x_s));
      end
      if (c == 23) begin
        // Final WRITE: each address holds the last value of its own term.
        check("last_addr_x", addr_x_s, 5);
        check("last_rd_w", rd_w_s, 5);
        check("last_rd_u", rd_u_s, 3);
        check("last_rd_h", rd_h_s, 1);
        check("last_rd_b", rd_b_s, 1);
        check("last_cur_t", t_s, 1);
        check("last_cur_cell", cell_s, 1);
      end
      if (c == 9) start_s = 1'b1;
      if (c == 10) start_s = 1'b0;
      tick();
    end
    check("busy_cycles", busy_n, 24);
    check("done_count", done_n, 1);
    check("done_cycle", done_c, 24);
    check("wr_c_match", wrc_bad, 0);
    check("write_count", wr_q.size(), 4);
    if (wr_q.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check("wr_addr", wr_q[i], i);
        check("wr_cycle", wrc_q[i], 5 + 6 * i);
      end
    check("acc_h_t0", acch_t0, 0);
    check("t0c1_nx", xs.size(), 3);
    if (xs.size() == 3)
      for (int i = 0; i < 3; i++) begin
        check("t0c1_addr_x", xs[i], i);
        check("t0c1_rd_w", ws[i], 3 + i);
      end
    check("t0c1_rd_b", b_bad, 0);
    check("t1c0_nh", hs.size(), 2);
    if (hs.size() == 2)
      for (int i = 0; i < 2; i++) begin
        check("t1c0_rd_h", hs[i], i);
        check("t1c0_rd_u", us[i], i);
      end
    check("t1c0_nx", x1.size(), 3);
    if (x1.size() == 3)
      for (int i = 0; i < 3; i++) check("t1c0_addr_x", x1[i], 3 + i);

    // Reset in the middle of the ACC of cell 1 at t=0.
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    repeat (8) tick();                  // c = 8: ACC with k=1, cell 1
    check("pre_rst_acc_x", acc_x_s, 1);
    check("pre_rst_cell", cell_s, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_busy", busy_s, 0);
    check("async_acc_x", acc_x_s, 0);
    check("async_addr_x", addr_x_s, 0);
    check("async_rd_w", rd_w_s, 0);
    check("async_rd_b", rd_b_s, 0);
    check("async_cell", cell_s, 0);
    check("async_wr_addr", wa_h_s, 0);
    wr_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wr_h_s) wr_seen++;
    end
    check("rst_no_write", wr_seen, 0);
    rst_n = 1'b1;
    tick();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    check("rerun_acc_rst", acc_rst_s, 1);
    check("rerun_cur_t", t_s, 0);
    check("rerun_cur_cell", cell_s, 0);
    repeat (5) tick();
    check("rerun_wr_h", wr_h_s, 1);
    check("rerun_wr_addr", wa_h_s, 0);
    lim = 0;
    while (!done_s && lim < 40) begin tick(); lim++; end
    check("rerun_done_seen", done_s, 1);

    // Default dimensions: 7 * 53 * 56 busy cycles.
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    busy_n = 0; lim = 0; last_wr = -1; wr_n = 0;
    max_x = 0; max_w = 0; max_u = 0; max_h = 0;
    while (!done_d && lim < 21000) begin
      if (busy_d) busy_n++;
      if (wr_h_d) begin last_wr = int'(wa_h_d); wr_n++; end
      if (int'(addr_x_d) > max_x) max_x = int'(addr_x_d);
      if (int'(rd_w_d) > max_w) max_w = int'(rd_w_d);
      if (int'(rd_u_d) > max_u) max_u = int'(rd_u_d);
      if (int'(rd_h_d) > max_h) max_h = int'(rd_h_d);
      tick();
      lim++;
    end
    check("def_done_seen", done_d, 1);
    check("def_busy_cycles", busy_n, 20776);
    check("def_write_count", wr_n, 371);
    check("def_last_wr", last_wr, 370);
    check("def_max_addr_x", max_x, 370);
    check("def_max_rd_w", max_w, 2808);
    check("def_max_rd_u", max_u, 2808);
    check("def_max_rd_h", max_h, 317);
    tick();
    check("def_idle_busy", busy_d, 0);
    check("def_idle_done", done_d, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
